// File: rtl/segre_mem_responder.sv
// Line-organised main-memory responder for the Segre instruction-cache fill protocol.
// Write-back support is compiled in with `define SEGRE_MEM_WRITE_EN; default build is read-only.
module segre_mem_responder #(
    parameter int    ADDR_SIZE             = 32,
    parameter int    CACHE_LINE_SIZE_BYTES = 16,
    parameter int    MEM_DEPTH_LINES       = 1024,
    parameter int    LATENCY               = 4,
    parameter string INIT_FILE             = ""
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  mem_rd_i,
    input  logic                                  mem_wr_i,
    input  logic [ADDR_SIZE-1:0]                  mem_addr_i,
    input  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] from_cache_line_i,
    output logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] cache_line_o,
    output logic                                  mem_ready_o,
    output logic                                  busy_o
);
    localparam int OFF_W = $clog2(CACHE_LINE_SIZE_BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

`ifdef SEGRE_MEM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    typedef logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] line_t;

    line_t            mem [MEM_DEPTH_LINES];
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_wr;
    logic [IDX_W-1:0] idx;
    line_t            line_q;

    logic             wr_req;
    logic             take;
    logic             resp_now;
    logic             resp_write;
    logic [IDX_W-1:0] resp_idx;
    line_t            resp_line;
    logic             addr_unused;

    // Only the index field selects a line; offset and upper bits wrap away.
    assign addr_unused = ^mem_addr_i;
    assign wr_req      = mem_wr_i & WRITE_EN;

    // With LATENCY=1 the response is produced on the acceptance edge itself,
    // so the response operands come straight from the inputs in IDLE.
    always_comb begin
        take       = 1'b0;
        resp_now   = 1'b0;
        resp_write = op_wr;
        resp_idx   = idx;
        resp_line  = line_q;
        if (state == IDLE) begin
            take       = wr_req | mem_rd_i;
            resp_now   = take && (LATENCY == 1);
            resp_write = wr_req;
            resp_idx   = mem_addr_i[OFF_W +: IDX_W];
            resp_line  = from_cache_line_i;
        end else if (state == WAIT) begin
            resp_now = (cnt == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            op_wr        <= 1'b0;
            mem_ready_o  <= 1'b0;
            busy_o       <= 1'b0;
            cache_line_o <= '0;
        end else begin
            mem_ready_o <= resp_now;
            if (resp_now)
                cache_line_o <= resp_write ? resp_line : mem[resp_idx];
            case (state)
                IDLE: begin
                    if (take) begin
                        op_wr  <= wr_req;
                        idx    <= mem_addr_i[OFF_W +: IDX_W];
                        line_q <= from_cache_line_i;
                        cnt    <= CNT_LOAD;
                        busy_o <= 1'b1;
                        state  <= (LATENCY == 1) ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESPOND;
                    else           cnt   <= cnt - 1'b1;
                end
                RESPOND: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Store updates are gated by reset so a dropped write-back never lands.
    always_ff @(posedge clk_i) begin
        if (!rst_i && resp_now && resp_write)
            mem[resp_idx] <= resp_line;
    end

endmodule
